// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: definitions shared by the write-port arbiter and its testbench.
//   arbState_t      arbiter FSM states. ARB_FORCE is only reachable when the
//                   design is built with WB_ARB_STARVE_GUARD_EN defined.
//   REG_ZERO        index of the hard-wired zero register.
//   starveCountWidth  bit width of the wait counter for a given STARVE_LIMIT.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_FORCE = 2'd2
    } arbState_t;

    localparam int REG_ZERO = 0;

    // The counter must hold values up to limit-1. Its width is never below 1 bit.
    function automatic int starveCountWidth(input int limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: bundles the WB stage request, the producer handshake
// and the register file write port.
//   slave  : the arbiter's view. It takes pipe*/mdu* requests and drives
//            mduReady, the regWrite* port, pipelineStall and mduPending.
//   master : the environment's view, with every direction reversed.
interface wb_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  pipeWriteEnable;
    logic [ADDR_WIDTH-1:0] pipeWriteAddr;
    logic [DATA_WIDTH-1:0] pipeWriteData;
    logic                  mduValid;
    logic [ADDR_WIDTH-1:0] mduAddr;
    logic [DATA_WIDTH-1:0] mduData;
    logic                  mduReady;
    logic                  regWriteEnable;
    logic [ADDR_WIDTH-1:0] regWriteAddr;
    logic [DATA_WIDTH-1:0] regWriteData;
    logic                  pipelineStall;
    logic                  mduPending;

    modport slave (
        input  pipeWriteEnable, pipeWriteAddr, pipeWriteData,
        input  mduValid, mduAddr, mduData,
        output mduReady, regWriteEnable, regWriteAddr, regWriteData,
        output pipelineStall, mduPending
    );

    modport master (
        output pipeWriteEnable, pipeWriteAddr, pipeWriteData,
        output mduValid, mduAddr, mduData,
        input  mduReady, regWriteEnable, regWriteAddr, regWriteData,
        input  pipelineStall, mduPending
    );
endinterface

// File: rtl/wb_hold_buffer.sv
// wb_hold_buffer: a one-entry holding register for a producer result.
//   clk, rst           clock and synchronous active-high reset (clears valid only)
//   load, loadAddr/Data  capture a new entry (the caller loads only when empty)
//   drain              release the entry after it has been written
//   valid, addr, data  the current entry
module wb_hold_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] loadAddr,
    input  logic [DATA_WIDTH-1:0] loadData,
    input  logic                  drain,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // The payload carries no reset because valid qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            addr <= loadAddr;
            data <= loadData;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register file write port between the WB stage
// and a long-latency producer (mul/div or load return). Pipeline writes win.
// A producer result waits in a one-entry buffer until it finds a free slot.
// Optional macro WB_ARB_STARVE_GUARD_EN: after STARVE_LIMIT busy cycles the
// pipeline is stalled for one cycle, and the buffered result is written in that cycle.
//   clk, rst   clock and synchronous active-high reset
//   bus        wb_write_arbiter_if.slave: pipe* request, mdu* handshake,
//              regWrite* port, pipelineStall, mduPending
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    wb_write_arbiter_if.slave bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadLimit
        $error("wb_write_arbiter: STARVE_LIMIT must be within 1..15");
    end

    arbState_t             state, stateNext;
    logic                  pipeBusy;
    logic                  bufLoad, bufDrain, bufValid;
    logic [ADDR_WIDTH-1:0] bufAddr;
    logic [DATA_WIDTH-1:0] bufData;
    logic                  portEnable;
    logic [ADDR_WIDTH-1:0] portAddr;
    logic [DATA_WIDTH-1:0] portData;

    // A write to r0 leaves the slot free.
    assign pipeBusy = bus.pipeWriteEnable && (bus.pipeWriteAddr != ADDR_WIDTH'(REG_ZERO));

    // A result for r0 completes the handshake but is never stored.
    assign bufLoad = (state == ARB_IDLE) && bus.mduValid &&
                     (bus.mduAddr != ADDR_WIDTH'(REG_ZERO));

    wb_hold_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) uHold (
        .clk     (clk),
        .rst     (rst),
        .load    (bufLoad),
        .loadAddr(bus.mduAddr),
        .loadData(bus.mduData),
        .drain   (bufDrain),
        .valid   (bufValid),
        .addr    (bufAddr),
        .data    (bufData)
    );

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = starveCountWidth(STARVE_LIMIT);

    logic [CNT_W-1:0] waitCount;
    logic             waitInc;
    logic             forceSlot;

    // waitCount holds the number of busy cycles the current entry has already lost.
    always_ff @(posedge clk) begin
        if (rst || bufLoad) begin
            waitCount <= '0;
        end else if (waitInc) begin
            waitCount <= waitCount + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        portEnable = 1'b0;
        portAddr   = '0;
        portData   = '0;
        bufDrain   = 1'b0;
`ifdef WB_ARB_STARVE_GUARD_EN
        waitInc    = 1'b0;
        forceSlot  = 1'b0;
`endif
        case (state)
            ARB_IDLE: begin
                if (pipeBusy) begin
                    portEnable = 1'b1;
                    portAddr   = bus.pipeWriteAddr;
                    portData   = bus.pipeWriteData;
                end
                if (bufLoad) begin
                    stateNext = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (pipeBusy) begin
                    portEnable = 1'b1;
                    portAddr   = bus.pipeWriteAddr;
                    portData   = bus.pipeWriteData;
`ifdef WB_ARB_STARVE_GUARD_EN
                    // This cycle is the entry's STARVE_LIMIT-th lost slot, so the next cycle is forced.
                    if (waitCount == CNT_W'(STARVE_LIMIT - 1)) begin
                        stateNext = ARB_FORCE;
                    end else begin
                        waitInc = 1'b1;
                    end
`endif
                end else begin
                    portEnable = 1'b1;
                    portAddr   = bufAddr;
                    portData   = bufData;
                    bufDrain   = 1'b1;
                    stateNext  = ARB_IDLE;
                end
            end
`ifdef WB_ARB_STARVE_GUARD_EN
            ARB_FORCE: begin
                forceSlot  = 1'b1;
                portEnable = 1'b1;
                portAddr   = bufAddr;
                portData   = bufData;
                bufDrain   = 1'b1;
                stateNext  = ARB_IDLE;
            end
`endif
            default: begin
                stateNext = ARB_IDLE;
            end
        endcase
    end

    // While reset is held, all outputs stay quiet, whatever the state register holds.
    assign bus.regWriteEnable = portEnable && !rst;
    assign bus.regWriteAddr   = portAddr;
    assign bus.regWriteData   = portData;
    assign bus.mduReady       = (state == ARB_IDLE) && !rst;
    assign bus.mduPending     = bufValid && !rst;
`ifdef WB_ARB_STARVE_GUARD_EN
    assign bus.pipelineStall  = forceSlot && !rst;
`else
    assign bus.pipelineStall  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: runs directed scenarios and then a random phase on
// wb_write_arbiter.
// A reference model expects each port write. It tracks whether a result is
// pending and how many busy slots that result has lost. Each expected write
// goes into a scoreboard queue. A monitor on the falling edge pops the queue
// and compares every write or stall that the DUT presents.
module tb_wb_write_arbiter;
    import wb_arb_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wb_write_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    exp_t sbq[$];
    exp_t monE;

    // State of the reference model.
    bit            mPending = 1'b0;
    int            mAge     = 0;
    logic [AW-1:0] mAddr    = '0;
    logic [DW-1:0] mData    = '0;
    bit            lastStall = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every write or stall that the DUT presents.
    always @(negedge clk) begin
        if (bus.regWriteEnable === 1'b1 || bus.pipelineStall === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpectedWrite", {bus.regWriteAddr, bus.regWriteData}, 64'h0);
                if (bus.regWriteAddr == '0 && bus.regWriteData == '0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpectedWrite: got write of r0 with zero data, expected none");
                end
            end else begin
                monE = sbq.pop_front();
                chk("writeEnable", bus.regWriteEnable, 1);
                chk("writeAddr", bus.regWriteAddr, monE.addr);
                chk("writeData", bus.regWriteData, monE.data);
                chk("stall", bus.pipelineStall, monE.stall);
            end
        end
    end

    // Run one cycle with the inputs as they stand now: set expectations, check, then advance the model.
    task automatic step();
        bit busy, forced, accept;
        busy   = bus.pipeWriteEnable && (bus.pipeWriteAddr != 0);
        forced = 1'b0;
        if (!rst) begin
            forced = GUARD && mPending && (mAge >= LIMIT);
            if (forced)
                sbq.push_back('{addr: mAddr, data: mData, stall: 1'b1});
            else if (busy)
                sbq.push_back('{addr: bus.pipeWriteAddr, data: bus.pipeWriteData, stall: 1'b0});
            else if (mPending)
                sbq.push_back('{addr: mAddr, data: mData, stall: 1'b0});
        end
        @(negedge clk);
        #1;
        if (rst) begin
            chk("rstWriteEnable", bus.regWriteEnable, 0);
            chk("rstStall", bus.pipelineStall, 0);
        end
        chk("mduReady", bus.mduReady, (!rst && !mPending) ? 1 : 0);
        chk("mduPending", bus.mduPending, (!rst && mPending) ? 1 : 0);
        chk("queueDrained", sbq.size(), 0);
        sbq.delete();
        if (rst) begin
            mPending = 1'b0;
        end else begin
            accept = bus.mduValid && !mPending;
            if (mPending) begin
                if (forced || !busy) mPending = 1'b0;
                else mAge++;
            end
            if (accept && bus.mduAddr != 0) begin
                mPending = 1'b1;
                mAge     = 0;
                mAddr    = bus.mduAddr;
                mData    = bus.mduData;
            end
        end
        lastStall = forced;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit pwe, input int pwa, input logic [DW-1:0] pwd,
                         input bit mv, input int ma, input logic [DW-1:0] md);
        rst                 = r;
        bus.pipeWriteEnable = pwe;
        bus.pipeWriteAddr   = AW'(pwa);
        bus.pipeWriteData   = pwd;
        bus.mduValid        = mv;
        bus.mduAddr         = AW'(ma);
        bus.mduData         = md;
        step();
    endtask

    initial begin
        bit            pwe, mv, r;
        int            pwa, ma;
        logic [DW-1:0] pwd, md;

        bus.pipeWriteEnable = 1'b1;
        bus.pipeWriteAddr   = 5'd5;
        bus.pipeWriteData   = 32'h1;
        bus.mduValid        = 1'b0;
        bus.mduAddr         = '0;
        bus.mduData         = '0;
        @(posedge clk);
        #1;

        // Reset with a pipeline write requested, then idle.
        drive(1, 1, 5, 32'h1, 0, 0, 0);
        drive(1, 1, 5, 32'h1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // A free slot drains the buffer on the next cycle.
        drive(0, 0, 0, 0, 1, 8, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Pipeline priority over a pending entry.
        drive(0, 0, 0, 0, 1, 9, 32'h11);
        drive(0, 1, 3, 32'h22, 0, 0, 0);
        drive(0, 1, 3, 32'h22, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // A write to r0 leaves the slot free.
        drive(0, 0, 0, 0, 1, 10, 32'h5);
        drive(0, 1, 0, 32'h7, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Starvation: the pipeline stays busy.
        drive(0, 0, 0, 0, 1, 11, 32'hABC);
        for (int i = 0; i < 7; i++) drive(0, 1, 4, 32'h44, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset while an entry waits: the entry is dropped.
        drive(0, 0, 0, 0, 1, 12, 32'hC0C0);
        drive(0, 1, 6, 32'h66, 0, 0, 0);
        drive(1, 1, 6, 32'h66, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // A result for r0 is accepted and discarded.
        drive(0, 0, 0, 0, 1, 0, 32'h99);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Random phase. After a stall, the WB request is presented again unchanged.
        pwe = 0; pwa = 0; pwd = 0;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 79) == 0);
            if (!lastStall) begin
                pwe = ($urandom_range(0, 99) < 75);
                pwa = $urandom_range(0, 31);
                pwd = $urandom;
            end
            mv = ($urandom_range(0, 99) < 40);
            ma = $urandom_range(0, 31);
            md = $urandom;
            drive(r, pwe, pwa, pwd, mv, ma, md);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
